// File: rtl/aq_axis_reduce_pkg.sv
// Shared definitions for the aq_axis_reduce configuration sequencer:
// register map, sequencer state encoding and fixed AXI4-Lite attributes.
package aq_axis_reduce_pkg;

   localparam logic [31:0] REG_ORG_X = 32'h0000_0000;
   localparam logic [31:0] REG_ORG_Y = 32'h0000_0004;
   localparam logic [31:0] REG_CNV_X = 32'h0000_0008;
   localparam logic [31:0] REG_CNV_Y = 32'h0000_000C;

   localparam logic [3:0] AXI_AWCACHE = 4'b0011;
   localparam logic [2:0] AXI_AWPROT  = 3'b000;
   localparam logic [3:0] AXI_WSTRB   = 4'hF;
   localparam logic [1:0] RESP_OKAY   = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WADDR = 2'd1,
      ST_WRESP = 2'd2,
      ST_SYNC  = 2'd3
   } seq_state_t;

   // Register offset for write number idx of a configuration sequence.
   function automatic logic [31:0] reg_offset(input logic [1:0] idx);
      case (idx)
         2'd0:    reg_offset = REG_ORG_X;
         2'd1:    reg_offset = REG_ORG_Y;
         2'd2:    reg_offset = REG_CNV_X;
         default: reg_offset = REG_CNV_Y;
      endcase
   endfunction

endpackage

// File: rtl/aq_axis_reduce_cfg_seq_if.sv
// AXI4-Lite write-only channel bundle between the sequencer and the
// aq_axis_reduce register slave.
interface aq_axis_reduce_cfg_seq_if;

   logic [31:0] awaddr;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   modport master (
      output awaddr, awcache, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bvalid, bresp,
      output bready
   );

   modport slave (
      input  awaddr, awcache, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bvalid, bresp,
      input  bready
   );

endinterface

// File: rtl/aq_axilm_wr_single.sv
// Single AXI4-Lite write engine: one start pulse issues AW and W together,
// each channel retires on its own handshake, then the B response is taken.
module aq_axilm_wr_single
   import aq_axis_reduce_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   output logic        addr_done,
   output logic        done,
   output logic [1:0]  resp,
   aq_axis_reduce_cfg_seq_if.master axi
);

   logic [31:0] awaddr_q;
   logic [31:0] wdata_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        aw_hs;
   logic        w_hs;

   assign aw_hs = awvalid_q & axi.awready;
   assign w_hs  = wvalid_q & axi.wready;

   // Address phase ends in the cycle where the last outstanding channel handshakes.
   assign addr_done = (awvalid_q | wvalid_q)
                    & (~awvalid_q | axi.awready)
                    & (~wvalid_q | axi.wready);
   assign done      = bready_q & axi.bvalid;
   assign resp      = axi.bresp;

   // Channel valids, held payload and response-ready sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         if (start) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= addr;
            wdata_q   <= data;
         end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
         end
         if (addr_done)  bready_q <= 1'b1;
         else if (done)  bready_q <= 1'b0;
      end
   end

   assign axi.awaddr  = awaddr_q;
   assign axi.awcache = AXI_AWCACHE;
   assign axi.awprot  = AXI_AWPROT;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = AXI_WSTRB;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

endmodule

// File: rtl/aq_axis_reduce_cfg_seq.sv
// Frame-synchronous configuration sequencer: staged dimensions are written
// to aq_axis_reduce at the next frame sync, and only then is the sync passed on.
module aq_axis_reduce_cfg_seq
   import aq_axis_reduce_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CW        = 16
) (
   input  logic          ACLK,
   input  logic          ARESETN,
   input  logic [CW-1:0] CFG_ORG_X,
   input  logic [CW-1:0] CFG_ORG_Y,
   input  logic [CW-1:0] CFG_CNV_X,
   input  logic [CW-1:0] CFG_CNV_Y,
   input  logic          CFG_UPDATE,
   input  logic          FSYNC_IN,
   output logic          FSYNC_OUT,
   output logic          BUSY,
   output logic          ERR,
   output logic          OVERRUN,
   aq_axis_reduce_cfg_seq_if.master m_axi
);

   seq_state_t    state;
   seq_state_t    state_next;
   logic [1:0]    idx;
   logic [1:0]    start_idx;
   logic          start;
   logic          addr_done;
   logic          wr_done;
   logic [1:0]    wr_resp;
   logic [CW-1:0] cfg_in  [4];
   logic [CW-1:0] pending [4];
   logic [CW-1:0] active  [4];
   logic [CW-1:0] start_val;
   logic [31:0]   start_addr;
   logic [31:0]   start_data;
   logic          dirty;
   logic          take_frame;
   logic          fsync_pass;
   logic          err_q;
   logic          overrun_q;

   assign cfg_in[0] = CFG_ORG_X;
   assign cfg_in[1] = CFG_ORG_Y;
   assign cfg_in[2] = CFG_CNV_X;
   assign cfg_in[3] = CFG_CNV_Y;

   assign take_frame = (state == ST_IDLE) & FSYNC_IN & dirty;

   // The first write reads pending directly because active is loaded on that same edge.
   assign start_val  = (state == ST_IDLE) ? pending[start_idx] : active[start_idx];
   assign start_data = 32'(start_val);
   assign start_addr = BASE_ADDR + reg_offset(start_idx);

   // Next-state decode; start launches a write on the edge that enters WADDR.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      start_idx  = idx;
      case (state)
         ST_IDLE: begin
            if (take_frame) begin
               state_next = ST_WADDR;
               start      = 1'b1;
               start_idx  = 2'd0;
            end
         end
         ST_WADDR: begin
            if (addr_done) state_next = ST_WRESP;
         end
         ST_WRESP: begin
            if (wr_done) begin
               if (idx == 2'd3) begin
                  state_next = ST_SYNC;
               end else begin
                  state_next = ST_WADDR;
                  start      = 1'b1;
                  start_idx  = idx + 2'd1;
               end
            end
         end
         ST_SYNC:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Index of the register currently being written.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)   idx <= 2'd0;
      else if (start) idx <= start_idx;
   end

   // Pending/active geometry sets; a same-cycle update lands in pending after the copy.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) begin
            pending[i] <= '0;
            active[i]  <= '0;
         end
         dirty <= 1'b0;
      end else begin
         if (take_frame) active <= pending;
         if (CFG_UPDATE) begin
            pending <= cfg_in;
            dirty   <= 1'b1;
         end else if (take_frame) begin
            dirty   <= 1'b0;
         end
      end
   end

   // Frame sync with nothing to program is forwarded one cycle later.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) fsync_pass <= 1'b0;
      else          fsync_pass <= (state == ST_IDLE) & FSYNC_IN & ~dirty;
   end

   // Sticky status flags; setting takes priority over the CFG_UPDATE clear.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_done && (wr_resp != RESP_OKAY)) err_q <= 1'b1;
         else if (CFG_UPDATE)                   err_q <= 1'b0;
         if (FSYNC_IN && (state != ST_IDLE))    overrun_q <= 1'b1;
         else if (CFG_UPDATE)                   overrun_q <= 1'b0;
      end
   end

   aq_axilm_wr_single u_wr (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .start     (start),
      .addr      (start_addr),
      .data      (start_data),
      .addr_done (addr_done),
      .done      (wr_done),
      .resp      (wr_resp),
      .axi       (m_axi)
   );

   assign FSYNC_OUT = fsync_pass | (state == ST_SYNC);
   assign BUSY      = (state != ST_IDLE);
   assign ERR       = err_q;
   assign OVERRUN   = overrun_q;

endmodule

// File: doc/aq_axis_reduce_cfg_seq.md
Name: aq_axis_reduce_cfg_seq

Overview:
Frame-synchronous configuration sequencer for aq_axis_reduce.
- Software or a host block stages new original/converted frame dimensions at any time.
- On the next FSYNC_IN pulse, the block programs the four reduce registers (0x00 ORG_X, 0x04 ORG_Y, 0x08 CNV_X, 0x0C CNV_Y) over an AXI4-Lite master write port.
- It then forwards the frame sync to the reduce block, so a geometry change never takes effect mid-frame.

Parameters:
BASE_ADDR, 32'h0000_0000, base address of the aq_axis_reduce register window
CW, 16, width of each staged dimension value (zero-extended to 32 bits on write)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
CFG_ORG_X  in  CW  staged original width
CFG_ORG_Y  in  CW  staged original height
CFG_CNV_X  in  CW  staged converted width
CFG_CNV_Y  in  CW  staged converted height
CFG_UPDATE  in  1  one-cycle pulse: capture CFG_* into the pending set and mark it dirty
FSYNC_IN  in  1  frame-start pulse from the video source
FSYNC_OUT  out  1  frame-start pulse to aq_axis_reduce
M_AXI_AWADDR  out  32  write address
M_AXI_AWCACHE  out  4  constant 4'b0011
M_AXI_AWPROT  out  3  constant 3'b000
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  data ready
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  response ready
M_AXI_BRESP  in  2  response code
BUSY  out  1  high while a write sequence is in progress
ERR  out  1  sticky: some BRESP != 2'b00; cleared by CFG_UPDATE
OVERRUN  out  1  sticky: FSYNC_IN arrived while BUSY; cleared by CFG_UPDATE

Behaviour:
- Reset: all outputs 0; pending set = 0; dirty = 0; FSM = IDLE. Reset asserted mid-sequence aborts immediately; no FSYNC_OUT is produced for the aborted frame.
- CFG_UPDATE: pending regs <= CFG_* and dirty <= 1 on the same edge. Accepted in any state.
- FSM states: IDLE, WADDR, WRESP, SYNC.
- IDLE, FSYNC_IN with dirty = 0:
  - FSYNC_OUT = 1 on the next cycle (1-cycle passthrough latency).
  - FSM stays IDLE.
- IDLE, FSYNC_IN with dirty = 1:
  - Copy pending -> active and clear dirty.
  - If CFG_UPDATE occurs in the same cycle, the active copy takes the old pending value, and pending/dirty take the new value (dirty stays 1).
  - Index idx <= 0, BUSY <= 1, go to WADDR.
- WADDR:
  - Drive AWADDR = BASE_ADDR + 4*idx and WDATA = zero-extended active[idx].
  - AWVALID and WVALID are asserted together in the first WADDR cycle.
  - Each is deasserted independently on its own handshake (VALID & READY). AW before W, W before AW and simultaneous handshakes are all legal.
  - AWADDR and WDATA stay stable while the corresponding VALID is high.
  - Once both handshakes are done, BREADY <= 1 and go to WRESP.
- WRESP:
  - On BVALID & BREADY: BREADY <= 0; if BRESP != 0, ERR <= 1 (sequence continues regardless).
  - If idx == 3, go to SYNC; else idx += 1 and return to WADDR.
  - A BVALID seen before both handshakes are done is ignored, because BREADY is low.
- SYNC: FSYNC_OUT = 1 for exactly one cycle, BUSY <= 0, go to IDLE.
- Latency: FSYNC_OUT is high in the cycle after the 4th B handshake.
- FSYNC_IN while BUSY: set OVERRUN; the pulse is dropped and never forwarded.
- FSYNC_IN in the SYNC cycle also counts as BUSY: it is dropped and sets OVERRUN.
- FSYNC_OUT is never high for two consecutive cycles.
- ERR and OVERRUN are cleared by CFG_UPDATE. If a set and a clear hit the same cycle, set wins.
- At most one outstanding AXI transaction at any time.

Decomposition:
- Package aq_axis_reduce_pkg:
  - register offsets REG_ORG_X = 0x00, REG_ORG_Y = 0x04, REG_CNV_X = 0x08, REG_CNV_Y = 0x0C;
  - FSM state encoding;
  - AXI constants (AWCACHE, AWPROT, WSTRB, RESP_OKAY).
- Sub-module aq_axilm_wr_single:
  - performs one AXI4-Lite write with independent AW/W handshakes and returns done plus the BRESP;
  - the sequencer instantiates it once and drives its addr/data/start.

Test Plan:
1. No CFG_UPDATE, FSYNC_IN pulse at cycle N -> FSYNC_OUT high at N+1 only; AWVALID never asserted.
2. CFG_UPDATE with 64/64/48/48, FSYNC_IN, slave always ready with BRESP = 0 -> writes in order (0x00,64), (0x04,64), (0x08,48), (0x0C,48); FSYNC_OUT one cycle after the 4th B; BUSY high throughout; ERR = 0.
3. Slave delays AWREADY by 3 cycles and WREADY by 0 on write 1, then the reverse on write 2 -> each VALID drops on its own handshake; BREADY rises only after both; data and addresses are correct.
4. BRESP = 2'b10 on write 2 of 4 -> ERR = 1; all 4 writes still issued; FSYNC_OUT still pulsed; next CFG_UPDATE clears ERR.
5. FSYNC_IN mid-sequence, plus CFG_UPDATE(32/32/16/16) mid-sequence -> OVERRUN = 1 and no extra FSYNC_OUT. The next FSYNC_IN writes 32/32/16/16.
6. ARESETN low during WRESP of write 2 -> all outputs 0, no FSYNC_OUT, dirty = 0; after release, FSYNC_IN is passthrough.
